mem_arbiter: RTL

Shares the single-ported, variable-latency unified memory between the instruction-fetch port and the data-memory port of the processor. It accepts one request at a time, with data taking priority over fetch. It sequences each access through issue, wait and response, and it rejects misaligned or timed-out accesses with an error. It sits between the fetch/memory stages and the memory model, and drives the stall signals consumed by pipeline control.

---
 rtl/mem_arbiter_pkg.sv | 6 +
 rtl/mem_arbiter.sv | 90 +++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM/owner types and default timeout for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data ports onto one variable-latency memory, data first
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  owner_t owner;
  logic cmd_wr, err_flag, kill, kill_nxt;
  logic dm_req, grant_dm, grant, misal, timeout, own_if, finish;
  logic [CW-1:0] cnt;
  logic [AW-1:0] g_addr;
  assign dm_req   = dm_rd | dm_wr;
  assign grant_dm = dm_req;
  assign grant    = dm_req | (if_req & ~if_flush);
  assign g_addr   = grant_dm ? dm_addr : if_addr;
  assign misal    = g_addr[0];
  assign timeout  = cnt == CW'(TIMEOUT);
  assign own_if   = state != IDLE && owner == OWN_IF;
  assign kill_nxt = kill | (own_if & if_flush);
  assign finish   = state == BUSY && (mem_ready || timeout);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (grant ? (misal ? RESP : BUSY) : IDLE) :
                state == BUSY ? ((mem_ready || timeout) ? RESP : BUSY) : IDLE;
  end
  always_comb begin
    mem_en   = state == BUSY;
    mem_wr   = mem_en & cmd_wr;
    if_done  = state == RESP && owner == OWN_IF && !kill;
    dm_done  = state == RESP && owner == OWN_DM;
    err      = err_flag && (if_done || dm_done);
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end
  // A killed fetch still runs to completion on the memory side; only its results are dropped.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner     <= OWN_IF;
      cmd_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      kill      <= 1'b0;
      err_flag  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      kill <= state_nxt == IDLE ? 1'b0 : kill_nxt;
      cnt  <= state_nxt == BUSY ? cnt + 1'b1 : '0;
      if (state == IDLE && grant) begin
        owner     <= grant_dm ? OWN_DM : OWN_IF;
        cmd_wr    <= grant_dm & dm_wr;
        mem_addr  <= g_addr;
        mem_wdata <= dm_wdata;
        err_flag  <= misal;
      end
      if (state == BUSY && !mem_ready && timeout) err_flag <= 1'b1;
      if (finish && owner == OWN_DM && !cmd_wr) dm_rdata <= mem_ready ? mem_rdata : '0;
      if (finish && owner == OWN_IF && !kill_nxt) if_rdata <= mem_ready ? mem_rdata : '0;
    end
endmodule
